// File: rtl/calc_sequencer_if.sv
// Handshake bundle between the calculator sequencer (master) and the
// button/ALU/datapath side (slave).
interface calc_sequencer_if;
    logic       button;
    logic [1:0] op_sel;
    logic       alu_done;
    logic       save_A;
    logic       save_B;
    logic [1:0] op_q;
    logic       alu_start;
    logic       show_result;
    logic       error;
    logic [2:0] state_dbg;

    modport master (
        input  button, op_sel, alu_done,
        output save_A, save_B, op_q, alu_start, show_result, error, state_dbg
    );

    modport slave (
        output button, op_sel, alu_done,
        input  save_A, save_B, op_q, alu_start, show_result, error, state_dbg
    );
endinterface

// File: rtl/calc_sequencer.sv
// Single-button calculator sequencer: operand capture, ALU start, result or error display.
// Optional macro DEBOUNCE_EN adds a stability filter in front of the press edge detector.
module calc_sequencer #(
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int ALU_MAX_CYCLES  = 64,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.master  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_GO = 3'd2;
    localparam logic [2:0] S_BUSY    = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int WDG_W = $clog2(ALU_MAX_CYCLES);

    if (TIMEOUT_CYCLES < 2 || ALU_MAX_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("calc_sequencer: parameter out of range");
    end

    logic             btn;
    logic             button_q;
    logic             press;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [WDG_W-1:0] wdg_cnt;
    logic             tmo_exp;
    logic             wdg_exp;
    logic             save_a_c;
    logic             save_b_c;
    logic             start_c;
    logic [1:0]       op_q;

`ifdef DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic            filt;
    logic [DB_W-1:0] db_cnt;

    // The filtered level only follows the button after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt   <= 1'b1;
            db_cnt <= '0;
        end else if (bus.button == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt   <= bus.button;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign btn = filt;
`else
    assign btn = bus.button;
`endif

    assign press   = btn & ~button_q;
    assign tmo_exp = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign wdg_exp = (wdg_cnt == WDG_W'(ALU_MAX_CYCLES - 1));

    always_comb begin
        state_nx = state;
        save_a_c = 1'b0;
        save_b_c = 1'b0;
        start_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    save_a_c = 1'b1;
                    state_nx = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (press) begin
                    save_b_c = 1'b1;
                    state_nx = S_WAIT_GO;
                end else if (tmo_exp) begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_GO: begin
                if (press) begin
                    start_c  = 1'b1;
                    state_nx = S_BUSY;
                end else if (tmo_exp) begin
                    state_nx = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.alu_done)  state_nx = S_SHOW;
                else if (wdg_exp)  state_nx = S_ERR;
            end
            S_SHOW, S_ERR: begin
                // Leaving SHOW/ERR consumes the press; it never doubles as operand A.
                if (press) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            button_q <= 1'b1;
            tmo_cnt  <= '0;
            wdg_cnt  <= '0;
            op_q     <= 2'd0;
        end else begin
            state    <= state_nx;
            button_q <= btn;
            if (save_b_c) op_q <= bus.op_sel;

            if (state_nx != state || press)
                tmo_cnt <= '0;
            else if ((state == S_WAIT_B || state == S_WAIT_GO) && !tmo_exp)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state_nx != state)
                wdg_cnt <= '0;
            else if (state == S_BUSY && !wdg_exp)
                wdg_cnt <= wdg_cnt + 1'b1;
        end
    end

    // Pulses are suppressed while rst is high so an aborted cycle emits nothing.
    assign bus.save_A      = save_a_c & ~rst;
    assign bus.save_B      = save_b_c & ~rst;
    assign bus.alu_start   = start_c  & ~rst;
    assign bus.op_q        = op_q;
    assign bus.show_result = (state == S_SHOW);
    assign bus.error       = (state == S_ERR);
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (also covers the DEBOUNCE_EN build).
module tb_calc_sequencer;
    localparam int T  = 32;
    localparam int M  = 8;
    localparam int DB = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot  = 0;
    int   n_pass = 0;

    calc_sequencer_if bus();

    calc_sequencer #(
        .TIMEOUT_CYCLES (T),
        .ALU_MAX_CYCLES (M),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push();
        bus.button = 1'b1;
        repeat (LAT) step();
        #1;
    endtask

    task automatic release_btn();
        step();
        bus.button = 1'b0;
        repeat (LAT + 1) step();
    endtask

    // Ends in the first BUSY cycle with the button released.
    task automatic go_busy();
        push(); release_btn();
        push(); release_btn();
        push(); step();
        bus.button = 1'b0;
    endtask

    task automatic test_reset();
        bus.button = 1'b1; bus.op_sel = 2'd0; bus.alu_done = 1'b0;
        rst = 1'b1;
        step(); step(); #1;
        n_tot++;
        if ({bus.save_A, bus.save_B, bus.alu_start} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {bus.save_A, bus.save_B, bus.alu_start});
        else n_pass++;
        rst = 1'b0;
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, bus.op_q, bus.save_A, bus.show_result, bus.error} !== 8'b000_00_000)
            $display("FAIL reset_state: got %b expected 00000000",
                     {bus.state_dbg, bus.op_q, bus.save_A, bus.show_result, bus.error});
        else n_pass++;
        bus.button = 1'b0;
        repeat (LAT + 1) step();
    endtask

    task automatic test_full_flow();
        push();
        n_tot++;
        if ({bus.save_A, bus.save_B, bus.alu_start} !== 3'b100)
            $display("FAIL flow_save_A: got %b expected 100", {bus.save_A, bus.save_B, bus.alu_start});
        else n_pass++;
        release_btn();
        n_tot++;
        if (bus.state_dbg !== 3'd1) $display("FAIL flow_wait_b: got %0d expected 1", bus.state_dbg);
        else n_pass++;
        bus.op_sel = 2'd2;
        push();
        n_tot++;
        if ({bus.save_A, bus.save_B, bus.alu_start} !== 3'b010)
            $display("FAIL flow_save_B: got %b expected 010", {bus.save_A, bus.save_B, bus.alu_start});
        else n_pass++;
        release_btn();
        bus.op_sel = 2'd1;
        n_tot++;
        if ({bus.state_dbg, bus.op_q} !== {3'd2, 2'd2})
            $display("FAIL flow_op_q: got state %0d op_q %0d expected state 2 op_q 2", bus.state_dbg, bus.op_q);
        else n_pass++;
        push();
        n_tot++;
        if ({bus.save_A, bus.save_B, bus.alu_start} !== 3'b001)
            $display("FAIL flow_start: got %b expected 001", {bus.save_A, bus.save_B, bus.alu_start});
        else n_pass++;
        step();
        bus.button = 1'b0;
        repeat (4) step();
        bus.alu_done = 1'b1;
        step();
        bus.alu_done = 1'b0;
        #1;
        n_tot++;
        if ({bus.state_dbg, bus.show_result, bus.op_q} !== {3'd4, 1'b1, 2'd2})
            $display("FAIL flow_show: got state %0d show %b op_q %0d expected 4 1 2",
                     bus.state_dbg, bus.show_result, bus.op_q);
        else n_pass++;
        repeat (LAT + 1) step();
        push();
        n_tot++;
        if ({bus.save_A, bus.state_dbg} !== {1'b0, 3'd4})
            $display("FAIL flow_show_press: got save_A %b state %0d expected 0 4", bus.save_A, bus.state_dbg);
        else n_pass++;
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, bus.show_result} !== {3'd0, 1'b0})
            $display("FAIL flow_idle: got state %0d show %b expected 0 0", bus.state_dbg, bus.show_result);
        else n_pass++;
        bus.button = 1'b0;
        repeat (LAT + 1) step();
    endtask

    task automatic test_held_button();
        int cnt = 0;
        bus.button = 1'b1;
        repeat (20) begin
            #1;
            if (bus.save_A) cnt++;
            step();
        end
        #1;
        n_tot++;
        if (cnt !== 1 || bus.state_dbg !== 3'd1)
            $display("FAIL held_one_press: got %0d pulses state %0d expected 1 pulse state 1", cnt, bus.state_dbg);
        else n_pass++;
        bus.button = 1'b0;
        repeat (T + 2) step();
    endtask

    task automatic test_timeout();
        logic seen = 1'b0;
        push();
        n_tot++;
        if (bus.save_A !== 1'b1) $display("FAIL tmo_save_A: got %b expected 1", bus.save_A);
        else n_pass++;
        step();
        bus.button = 1'b0;
        repeat (T - 1) begin
            #1;
            seen = seen | bus.save_B;
            step();
        end
        #1;
        seen = seen | bus.save_B;
        n_tot++;
        if (bus.state_dbg !== 3'd1) $display("FAIL tmo_last_cycle: got state %0d expected 1", bus.state_dbg);
        else n_pass++;
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, seen} !== {3'd0, 1'b0})
            $display("FAIL tmo_expire: got state %0d save_B seen %b expected 0 0", bus.state_dbg, seen);
        else n_pass++;
        push();
        step();
        bus.button = 1'b0;
        repeat (T - LAT - 1) step();
        push();
        n_tot++;
        if ({bus.save_B, bus.state_dbg} !== {1'b1, 3'd1})
            $display("FAIL tmo_press_wins: got save_B %b state %0d expected 1 1", bus.save_B, bus.state_dbg);
        else n_pass++;
        step(); #1;
        n_tot++;
        if (bus.state_dbg !== 3'd2) $display("FAIL tmo_to_wait_go: got state %0d expected 2", bus.state_dbg);
        else n_pass++;
        bus.button = 1'b0;
        repeat (LAT + 1) step();
        repeat (T) step();
        #1;
        n_tot++;
        if (bus.state_dbg !== 3'd0) $display("FAIL tmo_wait_go: got state %0d expected 0", bus.state_dbg);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        go_busy();
        repeat (M - 1) step();
        #1;
        n_tot++;
        if ({bus.state_dbg, bus.error} !== {3'd3, 1'b0})
            $display("FAIL wdg_still_busy: got state %0d error %b expected 3 0", bus.state_dbg, bus.error);
        else n_pass++;
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, bus.error} !== {3'd5, 1'b1})
            $display("FAIL wdg_error: got state %0d error %b expected 5 1", bus.state_dbg, bus.error);
        else n_pass++;
        push();
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, bus.error} !== {3'd0, 1'b0})
            $display("FAIL wdg_clear: got state %0d error %b expected 0 0", bus.state_dbg, bus.error);
        else n_pass++;
        bus.button = 1'b0;
        repeat (LAT + 1) step();
    endtask

    task automatic test_done_at_expiry();
        go_busy();
        repeat (M - 1) step();
        bus.alu_done = 1'b1;
        step();
        bus.alu_done = 1'b0;
        #1;
        n_tot++;
        if ({bus.state_dbg, bus.show_result, bus.error} !== {3'd4, 1'b1, 1'b0})
            $display("FAIL done_wins: got state %0d show %b error %b expected 4 1 0",
                     bus.state_dbg, bus.show_result, bus.error);
        else n_pass++;
        push();
        step();
        bus.button = 1'b0;
        repeat (LAT + 1) step();
        bus.alu_done = 1'b1;
        repeat (3) step();
        bus.alu_done = 1'b0;
        step(); #1;
        n_tot++;
        if ({bus.state_dbg, bus.show_result, bus.alu_start} !== 5'b000_00)
            $display("FAIL stray_done: got state %0d show %b start %b expected 0 0 0",
                     bus.state_dbg, bus.show_result, bus.alu_start);
        else n_pass++;
    endtask

    task automatic test_reset_in_busy();
        int cnt = 0;
        bus.op_sel = 2'd3;
        go_busy();
        bus.button = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        #1;
        n_tot++;
        if ({bus.save_A, bus.save_B, bus.alu_start} !== 3'b000)
            $display("FAIL rst_busy_pulses: got %b expected 000", {bus.save_A, bus.save_B, bus.alu_start});
        else n_pass++;
        step();
        rst = 1'b0;
        #1;
        n_tot++;
        if ({bus.state_dbg, bus.op_q, bus.error} !== {3'd0, 2'd0, 1'b0})
            $display("FAIL rst_busy_state: got state %0d op_q %0d error %b expected 0 0 0",
                     bus.state_dbg, bus.op_q, bus.error);
        else n_pass++;
        repeat (10) begin
            #1;
            if (bus.save_A) cnt++;
            step();
        end
        n_tot++;
        if (cnt !== 0) $display("FAIL rst_held_no_press: got %0d pulses expected 0", cnt);
        else n_pass++;
        bus.button = 1'b0;
        repeat (LAT + 1) step();
        push();
        n_tot++;
        if (bus.save_A !== 1'b1) $display("FAIL rst_repress: got %b expected 1", bus.save_A);
        else n_pass++;
        step();
        bus.button = 1'b0;
        repeat (T + LAT) step();
        #1;
        n_tot++;
        if (bus.state_dbg !== 3'd0) $display("FAIL rst_final_idle: got state %0d expected 0", bus.state_dbg);
        else n_pass++;
    endtask

`ifdef DEBOUNCE_EN
    task automatic test_glitch();
        int cnt = 0;
        bus.button = 1'b1;
        repeat (3) begin
            #1;
            if (bus.save_A) cnt++;
            step();
        end
        bus.button = 1'b0;
        repeat (LAT + 2) begin
            #1;
            if (bus.save_A) cnt++;
            step();
        end
        #1;
        n_tot++;
        if (cnt !== 0 || bus.state_dbg !== 3'd0)
            $display("FAIL glitch: got %0d pulses state %0d expected 0 0", cnt, bus.state_dbg);
        else n_pass++;
    endtask
`endif

    initial begin
        bus.button = 1'b0; bus.op_sel = 2'd0; bus.alu_done = 1'b0;
        test_reset();
        test_full_flow();
        test_held_button();
        test_timeout();
        test_watchdog();
        test_done_at_expiry();
        test_reset_in_busy();
`ifdef DEBOUNCE_EN
        test_glitch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
